// File: rtl/row_scan_display.sv
// ---------------------------------------------------------------------------
// row_scan_display
//
// Purpose:
//   Display-side consumer of the game FSM's row-write interface. It keeps a
//   ROWS x 8 frame memory and multiplexes it onto an LED matrix one row at a
//   time. Every row slot starts with a blanking gap so that the previous row's
//   column drive has fully decayed before the next row is enabled (no ghosting).
//
// Ports:
//   clk          in   1      system clock, all logic on the rising edge
//   reset        in   1      asynchronous, active-low reset
//   writeStrobe  in   1      write val into row rowIndex this cycle
//   rowIndex     in   IDX_W  target row of the write (>= ROWS is ignored)
//   val          in   8      row pattern, bit7 = leftmost column
//   clrarray     in   1      level: clear the whole frame memory while high
//   rowSel       out  ROWS   one-hot active-low row enable, all ones = blank
//   colData      out  8      active-high column data for the selected row
//   frameStart   out  1      one-cycle pulse when scanning wraps to row 0
//
// Scan timing:
//   Each row slot is SCAN_DIV cycles: BLANK_CYCLES of blank followed by
//   SCAN_DIV-BLANK_CYCLES of drive. All pin outputs come straight from
//   flops so the board drivers never see decode glitches.
// ---------------------------------------------------------------------------
module row_scan_display #(
  parameter int ROWS         = 8,
  parameter int IDX_W        = 3,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeStrobe,
  input  logic [IDX_W-1:0] rowIndex,
  input  logic [7:0]       val,
  input  logic             clrarray,
  output logic [ROWS-1:0]  rowSel,
  output logic [7:0]       colData,
  output logic             frameStart
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);

  // Two live states; the extra encodings exist only so that a corrupted
  // state register has a defined way back to BLANK.
  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  // -------------------------------------------------------------------------
  // Frame memory
  // -------------------------------------------------------------------------
  // Held in flops rather than block RAM: a whole-array clear must complete
  // in a single cycle, which a RAM port cannot do.
  logic [7:0] mem_reg [ROWS];
  logic [ROWS-1:0] row_we;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    // Out-of-range rowIndex values match no row, so they fall through
    // without any side effect.
    assign row_we[gi] = writeStrobe && (rowIndex == IDX_W'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_reg[gi] <= '0;
      end else if (clrarray) begin
        // Clear has priority over a coincident write.
        mem_reg[gi] <= '0;
      end else if (row_we[gi]) begin
        mem_reg[gi] <= val;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM
  // -------------------------------------------------------------------------
  logic [1:0]       state_reg,    state_next;
  logic [CNT_W-1:0] phase_reg,    phase_next;
  logic [ROW_W-1:0] scan_row_reg, scan_row_next;
  logic [ROWS-1:0]  row_sel_reg,  row_sel_next;
  logic [7:0]       col_reg,      col_next;
  logic             frame_reg,    frame_next;

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    scan_row_next = scan_row_reg;
    row_sel_next  = row_sel_reg;
    col_next      = col_reg;
    frame_next    = 1'b0;

    case (state_reg)
      ST_BLANK: begin
        row_sel_next = '1;
        col_next     = '0;
        if (phase_reg == BLANK_LAST) begin
          state_next   = ST_DRIVE;
          phase_next   = '0;
          row_sel_next = ~(ROWS'(1) << scan_row_reg);
          // Snapshot taken from the memory as it stood before this edge;
          // a write landing on the same edge shows up one frame later.
          col_next     = mem_reg[scan_row_reg];
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      ST_DRIVE: begin
        // rowSel/colData hold their snapshot for the whole drive interval,
        // so writes arriving mid-slot cannot tear the displayed row.
        if (phase_reg == DRIVE_LAST) begin
          state_next   = ST_BLANK;
          phase_next   = '0;
          row_sel_next = '1;
          col_next     = '0;
          if (scan_row_reg == ROW_LAST) begin
            scan_row_next = '0;
            frame_next    = 1'b1;
          end else begin
            scan_row_next = scan_row_reg + 1'b1;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      default: begin
        state_next   = ST_BLANK;
        phase_next   = '0;
        row_sel_next = '1;
        col_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_BLANK;
      phase_reg    <= '0;
      scan_row_reg <= '0;
      row_sel_reg  <= '1;
      col_reg      <= '0;
      frame_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      scan_row_reg <= scan_row_next;
      row_sel_reg  <= row_sel_next;
      col_reg      <= col_next;
      frame_reg    <= frame_next;
    end
  end

  assign rowSel     = row_sel_reg;
  assign colData    = col_reg;
  assign frameStart = frame_reg;

endmodule

// File: tb/tb_row_scan_display.sv
// ---------------------------------------------------------------------------
// tb_row_scan_display
//
// Directed bench for row_scan_display with SCAN_DIV=8, BLANK_CYCLES=2,
// ROWS=8. Edge numbers count rising clock edges after reset release, so
// row r of frame f goes BLANK->DRIVE on edge 64*f + 8*r + 2 and back to
// BLANK on edge 64*f + 8*r + 8. Outputs are sampled 1 time unit after an
// edge, or on the falling edge for the rowSel one-hot monitor.
// ---------------------------------------------------------------------------
module tb_row_scan_display;

  localparam int ROWS         = 8;
  localparam int IDX_W        = 3;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             writeStrobe = 1'b0;
  logic [IDX_W-1:0] rowIndex = '0;
  logic [7:0]       val = '0;
  logic             clrarray = 1'b0;
  logic [ROWS-1:0]  rowSel;
  logic [7:0]       colData;
  logic             frameStart;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  row_scan_display #(
    .ROWS         (ROWS),
    .IDX_W        (IDX_W),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .writeStrobe (writeStrobe),
    .rowIndex    (rowIndex),
    .val         (val),
    .clrarray    (clrarray),
    .rowSel      (rowSel),
    .colData     (colData),
    .frameStart  (frameStart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_edge(input int target);
    step(target - cyc);
  endtask

  task automatic wr(input int idx, input logic [7:0] v);
    writeStrobe = 1'b1;
    rowIndex    = IDX_W'(idx);
    val         = v;
  endtask

  task automatic wr_off();
    writeStrobe = 1'b0;
    rowIndex    = '0;
    val         = '0;
  endtask

  // At most one row may be enabled at any time.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(~rowSel)) else begin
        errors++;
        $error("FAIL rowsel_onehot observed=%h expected=at most one low bit", rowSel);
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    #2 reset = 1'b0;
    #1;
    chk("rst_rowsel", rowSel, 8'hFF);
    chk("rst_col", colData, 8'h00);
    chk("rst_frame", {7'd0, frameStart}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_rowsel", rowSel, 8'hFF);
    mon_en = 1'b1;

    // ---------------- run 1: empty memory, scan timing ----------------
    reset = 1'b1;
    cyc   = 0;
    chk("r1_e0_rowsel", rowSel, 8'hFF);
    step(1);
    chk("r1_e1_rowsel", rowSel, 8'hFF);
    step(1);
    chk("r1_e2_rowsel", rowSel, 8'hFE);
    chk("r1_e2_col", colData, 8'h00);
    goto_edge(7);
    chk("r1_e7_rowsel", rowSel, 8'hFE);
    goto_edge(8);
    chk("r1_e8_rowsel", rowSel, 8'hFF);
    goto_edge(9);
    chk("r1_e9_rowsel", rowSel, 8'hFF);
    goto_edge(10);
    chk("r1_e10_rowsel", rowSel, 8'hFD);
    chk("r1_e10_col", colData, 8'h00);
    for (int k = 11; k <= 130; k++) begin
      goto_edge(k);
      chk("r1_frame", {7'd0, frameStart}, (k == 64 || k == 128) ? 8'h01 : 8'h00);
    end
    chk("r1_e130_rowsel", rowSel, 8'hFE);

    // ---------------- run 2: writes before first drive ----------------
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("r2_rst_rowsel", rowSel, 8'hFF);
    @(negedge clk);
    wr(0, 8'hE0);
    reset = 1'b1;
    cyc   = 0;
    step(1);
    wr(1, 8'h18);
    step(1);
    wr_off();
    chk("r2_e2_rowsel", rowSel, 8'hFE);
    chk("r2_e2_col", colData, 8'hE0);
    goto_edge(7);
    chk("r2_e7_col", colData, 8'hE0);
    goto_edge(8);
    chk("r2_e8_rowsel", rowSel, 8'hFF);
    chk("r2_e8_col", colData, 8'h00);
    goto_edge(9);
    chk("r2_e9_col", colData, 8'h00);
    goto_edge(10);
    chk("r2_e10_rowsel", rowSel, 8'hFD);
    chk("r2_e10_col", colData, 8'h18);
    goto_edge(15);
    chk("r2_e15_col", colData, 8'h18);
    goto_edge(16);
    chk("r2_e16_col", colData, 8'h00);

    // ---------------- write during row 3 drive: no tearing ----------------
    goto_edge(27);
    chk("r3_e27_rowsel", rowSel, 8'hF7);
    chk("r3_e27_col", colData, 8'h00);
    wr(3, 8'hFF);
    step(1);
    wr_off();
    chk("r3_e28_col", colData, 8'h00);
    goto_edge(31);
    chk("r3_e31_rowsel", rowSel, 8'hF7);
    chk("r3_e31_col", colData, 8'h00);
    goto_edge(90);
    chk("r3_next_rowsel", rowSel, 8'hF7);
    chk("r3_next_col", colData, 8'hFF);

    // ---------------- write on the row 5 BLANK->DRIVE edge ----------------
    wr(5, 8'hF0);
    step(1);
    wr_off();
    goto_edge(105);
    wr(5, 8'h0F);
    step(1);
    wr_off();
    chk("r5_edge_rowsel", rowSel, 8'hDF);
    chk("r5_edge_col", colData, 8'hF0);
    goto_edge(111);
    chk("r5_e111_col", colData, 8'hF0);
    goto_edge(170);
    chk("r5_next_rowsel", rowSel, 8'hDF);
    chk("r5_next_col", colData, 8'h0F);

    // ---------------- fill with AA, then clear beats write ----------------
    for (int r = 0; r < ROWS; r++) begin
      wr(r, 8'hAA);
      step(1);
    end
    wr_off();
    // Row 6 went to DRIVE on edge 178 and took the AA written on edge 177.
    chk("fill_row6_rowsel", rowSel, 8'hBF);
    chk("fill_row6_col", colData, 8'hAA);
    clrarray = 1'b1;
    wr(2, 8'h55);
    step(1);
    clrarray = 1'b0;
    wr_off();
    for (int r = 0; r < ROWS; r++) begin
      logic [7:0] sel_exp;
      sel_exp = ~(8'h01 << r);
      goto_edge(194 + 8 * r);
      chk("clr_rowsel", rowSel, sel_exp);
      chk("clr_col", colData, 8'h00);
    end

    // ---------------- async reset mid-DRIVE of row 4 ----------------
    goto_edge(256);
    wr(0, 8'h3C);
    step(1);
    wr_off();
    goto_edge(292);
    chk("ar_pre_rowsel", rowSel, 8'hEF);
    #2 reset = 1'b0;
    #1;
    chk("ar_rowsel", rowSel, 8'hFF);
    chk("ar_col", colData, 8'h00);
    chk("ar_frame", {7'd0, frameStart}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    step(1);
    chk("ar_e1_rowsel", rowSel, 8'hFF);
    step(1);
    chk("ar_e2_rowsel", rowSel, 8'hFE);
    chk("ar_e2_col", colData, 8'h00);
    goto_edge(10);
    chk("ar_e10_rowsel", rowSel, 8'hFD);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
